// File: rtl/fifo_mc_pkg.sv
// Shared types, default sizing and the round-robin helper for the multi-channel clearable FIFO.
// The bench's reference model calls rr_next as well.
package fifo_mc_pkg;

    localparam int unsigned NUM_CHAN   = 4;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned CHAN_W     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1);
    localparam int unsigned MAX_CHAN   = 64;

    typedef logic [CHAN_W-1:0] chan_idx_t;
    typedef logic [CNT_W-1:0]  usage_t;

    // First eligible channel at or after ptr, wrapping modulo n; returns ptr when nothing is eligible.
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input logic [MAX_CHAN-1:0] eligible,
                                            input int unsigned n);
        int unsigned idx;
        rr_next = ptr;
        for (int k = MAX_CHAN - 1; k >= 0; k--) begin
            if (k < int'(n)) begin
                idx = (ptr + int'(k)) % n;
                if (eligible[idx[5:0]]) begin
                    rr_next = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/fifo_clearable_chan.sv
// One FIFO channel: circular storage, wrap-around pointers, a fill counter and a synchronous clear.
module fifo_clearable_chan
    import fifo_mc_pkg::*;
#(
    parameter int unsigned Depth     = DEPTH,
    parameter int unsigned DataWidth = DATA_WIDTH,
    localparam int unsigned CntW     = $clog2(Depth + 1),
    localparam int unsigned PtrW     = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DataWidth-1:0] wdata,
    output logic [DataWidth-1:0] rdata,
    output logic [CntW-1:0]      usage,
    output logic                 full,
    output logic                 empty
);

    logic [DataWidth-1:0] mem_r [Depth];
    logic [PtrW-1:0]      wr_ptr_r;
    logic [PtrW-1:0]      rd_ptr_r;
    logic [CntW-1:0]      cnt_r;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : p + 1'b1;
    endfunction

    // Pointers and fill level; a clear wins over any handshake on this channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push) wr_ptr_r <= next_ptr(wr_ptr_r);
            if (pop)  rd_ptr_r <= next_ptr(rd_ptr_r);
            if (push && !pop) begin
                cnt_r <= cnt_r + 1'b1;
            end else if (!push && pop) begin
                cnt_r <= cnt_r - 1'b1;
            end
        end
    end

    // Payload storage, deliberately left without reset.
    always_ff @(posedge clk) begin
        if (push) mem_r[wr_ptr_r] <= wdata;
    end

    assign rdata = mem_r[rd_ptr_r];
    assign usage = cnt_r;
    assign full  = (cnt_r == CntW'(Depth));
    assign empty = (cnt_r == {CntW{1'b0}});

endmodule

// File: rtl/fifo_clearable_mc_chk.sv
// Protocol checker: push channel range and grant stability under backpressure.
module fifo_clearable_mc_chk #(
    parameter int unsigned NumChan   = 4,
    parameter int unsigned ChanW     = 2,
    parameter int unsigned DataWidth = 32
) (
    input logic                 clk,
    input logic                 rst,
    input logic [NumChan-1:0]   clear,
    input logic                 inp_valid,
    input logic [ChanW-1:0]     inp_chan,
    input logic                 oup_valid,
    input logic                 oup_ready,
    input logic [ChanW-1:0]     oup_chan,
    input logic [DataWidth-1:0] oup_data
);

    a_chan_range: assert property (@(posedge clk) disable iff (rst)
        inp_valid |-> (32'(inp_chan) < NumChan));

    // A stalled grant holds unless its own channel is being cleared.
    a_grant_stable: assert property (@(posedge clk) disable iff (rst)
        (oup_valid && !oup_ready) |=>
            (clear[$past(oup_chan)] || (oup_valid && $stable(oup_chan) && $stable(oup_data))));

endmodule

// File: rtl/fifo_clearable_mc.sv
// Multi-channel clearable FIFO: tagged push demux, round-robin pop arbitration with a
// backpressure grant lock. Per-channel storage lives in fifo_clearable_chan.
module fifo_clearable_mc
    import fifo_mc_pkg::*;
#(
    parameter int unsigned NumChan   = NUM_CHAN,
    parameter int unsigned Depth     = DEPTH,
    parameter int unsigned DataWidth = DATA_WIDTH,
    localparam int unsigned ChanW    = (NumChan > 1) ? $clog2(NumChan) : 1,
    localparam int unsigned CntW     = $clog2(Depth + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumChan-1:0]      clear_i,
    input  logic [DataWidth-1:0]    inp_data_i,
    input  logic [ChanW-1:0]        inp_chan_i,
    input  logic                    inp_valid_i,
    output logic                    inp_ready_o,
    output logic [DataWidth-1:0]    oup_data_o,
    output logic [ChanW-1:0]        oup_chan_o,
    output logic                    oup_valid_o,
    input  logic                    oup_ready_i,
    output logic [NumChan*CntW-1:0] usage_o,
    output logic [NumChan-1:0]      full_o,
    output logic [NumChan-1:0]      empty_o
);

    logic [NumChan-1:0]   push_s;
    logic [NumChan-1:0]   pop_s;
    logic [NumChan-1:0]   eligible_s;
    logic [DataWidth-1:0] head_s [NumChan];
    logic [MAX_CHAN-1:0]  elig_wide_s;
    logic [ChanW-1:0]     rr_grant_s;
    logic [ChanW-1:0]     grant_s;
    logic [ChanW-1:0]     rr_ptr_r;
    logic [ChanW-1:0]     lock_chan_r;
    logic                 lock_r;
    logic                 chan_ok_s;

    assign chan_ok_s   = (32'(inp_chan_i) < NumChan);
    assign inp_ready_o = chan_ok_s && !full_o[inp_chan_i] && !clear_i[inp_chan_i];
    assign eligible_s  = ~empty_o & ~clear_i;

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        assign push_s[c] = inp_valid_i && inp_ready_o && (inp_chan_i == ChanW'(c));
        assign pop_s[c]  = oup_valid_o && oup_ready_i && (grant_s == ChanW'(c));

        fifo_clearable_chan #(
            .Depth     (Depth),
            .DataWidth (DataWidth)
        ) u_chan (
            .clk   (clk_i),
            .rst   (rst_i),
            .clear (clear_i[c]),
            .push  (push_s[c]),
            .pop   (pop_s[c]),
            .wdata (inp_data_i),
            .rdata (head_s[c]),
            .usage (usage_o[c*CntW +: CntW]),
            .full  (full_o[c]),
            .empty (empty_o[c])
        );
    end

    // Grant selection: a locked grant survives until its handshake or until its channel drops out.
    always_comb begin
        elig_wide_s                = '0;
        elig_wide_s[NumChan-1:0]   = eligible_s;
        rr_grant_s = ChanW'(rr_next(32'(rr_ptr_r), elig_wide_s, NumChan));
        if (lock_r && eligible_s[lock_chan_r]) begin
            grant_s = lock_chan_r;
        end else begin
            grant_s = rr_grant_s;
        end
    end

    assign oup_valid_o = |eligible_s;
    assign oup_chan_o  = grant_s;
    assign oup_data_o  = head_s[grant_s];

    // Round-robin pointer advance and backpressure lock capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_r    <= '0;
            lock_r      <= 1'b0;
            lock_chan_r <= '0;
        end else begin
            if (oup_valid_o && oup_ready_i) begin
                rr_ptr_r <= (32'(grant_s) == NumChan - 1) ? {ChanW{1'b0}} : grant_s + 1'b1;
            end
            if (oup_valid_o && !oup_ready_i) begin
                lock_r      <= 1'b1;
                lock_chan_r <= grant_s;
            end else begin
                lock_r      <= 1'b0;
            end
        end
    end

    fifo_clearable_mc_chk #(
        .NumChan   (NumChan),
        .ChanW     (ChanW),
        .DataWidth (DataWidth)
    ) u_chk (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear     (clear_i),
        .inp_valid (inp_valid_i),
        .inp_chan  (inp_chan_i),
        .oup_valid (oup_valid_o),
        .oup_ready (oup_ready_i),
        .oup_chan  (oup_chan_o),
        .oup_data  (oup_data_o)
    );

endmodule

// File: tb/tb_fifo_clearable_mc.sv
// Scoreboard bench for fifo_clearable_mc: per-channel expected queues filled on accepted
// pushes and consumed on pop handshakes, with a reference arbiter for the expected grant.
module tb_fifo_clearable_mc;
    import fifo_mc_pkg::*;

    localparam int NC = 4;
    localparam int DP = 8;
    localparam int DW = 32;
    localparam int CW = 2;
    localparam int UW = 4;

    typedef logic [DW-1:0] q_t [$];

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   clear;
    logic [DW-1:0]   inp_data;
    logic [CW-1:0]   inp_chan;
    logic            inp_valid;
    logic            inp_ready;
    logic [DW-1:0]   oup_data;
    logic [CW-1:0]   oup_chan;
    logic            oup_valid;
    logic            oup_ready;
    logic [NC*UW-1:0] usage;
    logic [NC-1:0]   full;
    logic [NC-1:0]   empty;

    q_t          exp_q [NC];
    int unsigned m_rr;
    bit          m_lock;
    int unsigned m_lock_chan;
    int          n_checks = 0;
    int          n_passed = 0;

    always #5 clk = ~clk;

    fifo_clearable_mc #(.NumChan(NC), .Depth(DP), .DataWidth(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .inp_data_i  (inp_data),
        .inp_chan_i  (inp_chan),
        .inp_valid_i (inp_valid),
        .inp_ready_o (inp_ready),
        .oup_data_o  (oup_data),
        .oup_chan_o  (oup_chan),
        .oup_valid_o (oup_valid),
        .oup_ready_i (oup_ready),
        .usage_o     (usage),
        .full_o      (full),
        .empty_o     (empty)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, compare against the model, then advance the model.
    task automatic cycle(input bit v, input int ch, input logic [DW-1:0] d,
                         input bit rdy, input logic [NC-1:0] clr);
        logic [63:0]      elig;
        logic [NC*UW-1:0] exp_usage;
        logic [NC-1:0]    exp_full;
        logic [NC-1:0]    exp_empty;
        bit               m_valid;
        bit               m_ready;
        int unsigned      grant;
        @(negedge clk);
        inp_valid = v;
        inp_chan  = CW'(ch);
        inp_data  = d;
        oup_ready = rdy;
        clear     = clr;
        #1;
        elig = '0;
        for (int c = 0; c < NC; c++) begin
            elig[c]               = (exp_q[c].size() > 0) && !clr[c];
            exp_usage[c*UW +: UW] = UW'(exp_q[c].size());
            exp_full[c]           = (exp_q[c].size() == DP);
            exp_empty[c]          = (exp_q[c].size() == 0);
        end
        m_valid = |elig;
        grant   = (m_lock && elig[m_lock_chan]) ? m_lock_chan : rr_next(m_rr, elig, NC);
        m_ready = (exp_q[ch].size() < DP) && !clr[ch];
        check_eq("inp_ready", 64'(inp_ready), 64'(m_ready));
        check_eq("oup_valid", 64'(oup_valid), 64'(m_valid));
        check_eq("usage", 64'(usage), 64'(exp_usage));
        check_eq("full", 64'(full), 64'(exp_full));
        check_eq("empty", 64'(empty), 64'(exp_empty));
        if (m_valid) begin
            check_eq("oup_chan", 64'(oup_chan), 64'(grant));
            check_eq("oup_data", 64'(oup_data), 64'(exp_q[grant][0]));
        end
        if (m_valid && rdy) begin
            void'(exp_q[grant].pop_front());
            m_rr = (grant + 1) % NC;
        end
        if (v && m_ready) exp_q[ch].push_back(d);
        for (int c = 0; c < NC; c++) begin
            if (clr[c]) exp_q[c].delete();
        end
        if (m_valid && !rdy) begin
            m_lock      = 1'b1;
            m_lock_chan = grant;
        end else begin
            m_lock = 1'b0;
        end
    endtask

    task automatic drain();
        repeat (40) cycle(0, 0, '0, 1'b1, '0);
    endtask

    // Reset asserted between clock edges; outputs must collapse before the next edge.
    task automatic reset_pulse();
        @(negedge clk);
        inp_valid = 1'b0;
        oup_ready = 1'b0;
        clear     = '0;
        #3 rst = 1'b1;
        #1;
        check_eq("rst_usage", 64'(usage), 64'd0);
        check_eq("rst_valid", 64'(oup_valid), 64'd0);
        check_eq("rst_empty", 64'(empty), 64'hF);
        for (int c = 0; c < NC; c++) exp_q[c].delete();
        m_rr   = 0;
        m_lock = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        clear     = '0;
        inp_data  = '0;
        inp_chan  = '0;
        inp_valid = 1'b0;
        oup_ready = 1'b0;
        m_rr      = 0;
        m_lock    = 1'b0;
        m_lock_chan = 0;
        #12;
        check_eq("reset_usage", 64'(usage), 64'd0);
        check_eq("reset_empty", 64'(empty), 64'hF);
        check_eq("reset_full", 64'(full), 64'd0);
        check_eq("reset_valid", 64'(oup_valid), 64'd0);
        check_eq("reset_ready", 64'(inp_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Fill channel 2 to the top, try one more, then drain in order.
        for (int i = 0; i < DP; i++) cycle(1, 2, DW'(32'h10 + i), 1'b0, '0);
        cycle(1, 2, 32'h18, 1'b0, '0);
        check_eq("fill_full2", 64'(full[2]), 64'd1);
        check_eq("fill_ready", 64'(inp_ready), 64'd0);
        for (int i = 0; i < DP; i++) begin
            cycle(0, 0, '0, 1'b1, '0);
            check_eq("fill_pop_data", 64'(oup_data), 64'(32'h10 + i));
            check_eq("fill_pop_chan", 64'(oup_chan), 64'd2);
        end
        cycle(0, 0, '0, 1'b1, '0);
        check_eq("fill_empty2", 64'(empty[2]), 64'd1);

        // Round robin from pointer 0; ch0 re-pushed mid-stream is served after ch3.
        reset_pulse();
        cycle(1, 0, 32'hA0, 1'b0, '0);
        cycle(1, 1, 32'hA1, 1'b0, '0);
        cycle(1, 3, 32'hA3, 1'b0, '0);
        cycle(0, 0, '0, 1'b1, '0);
        check_eq("rr_g0", 64'(oup_chan), 64'd0);
        cycle(1, 0, 32'hB0, 1'b1, '0);
        check_eq("rr_g1", 64'(oup_chan), 64'd1);
        cycle(0, 0, '0, 1'b1, '0);
        check_eq("rr_g3", 64'(oup_chan), 64'd3);
        cycle(0, 0, '0, 1'b1, '0);
        check_eq("rr_g0b", 64'(oup_chan), 64'd0);
        cycle(0, 0, '0, 1'b1, '0);
        check_eq("rr_idle", 64'(oup_valid), 64'd0);

        // Backpressure lock: rr pointer at 1, grant on ch3, pushes land on ch1 meanwhile.
        drain();
        cycle(1, 0, 32'h01, 1'b1, '0);
        cycle(0, 0, '0, 1'b1, '0);
        cycle(1, 3, 32'h30, 1'b0, '0);
        cycle(0, 0, '0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, DW'(32'h40 + i), 1'b0, '0);
            check_eq("lock_chan", 64'(oup_chan), 64'd3);
            check_eq("lock_data", 64'(oup_data), 64'h30);
        end

        // Clear isolation: ch1 flushed alongside a refused push, ch2 untouched.
        drain();
        for (int i = 0; i < 5; i++) cycle(1, 1, DW'(32'hB0 + i), 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle(1, 2, DW'(32'hC0 + i), 1'b0, '0);
        cycle(1, 1, 32'hAA, 1'b0, 4'b0010);
        check_eq("clr_refused", 64'(inp_ready), 64'd0);
        cycle(0, 0, '0, 1'b0, '0);
        check_eq("clr_usage1", 64'(usage[1*UW +: UW]), 64'd0);
        check_eq("clr_usage2", 64'(usage[2*UW +: UW]), 64'd3);
        drain();

        // Clearing the locked channel hands the grant to ch3.
        cycle(1, 1, 32'hD1, 1'b0, '0);
        cycle(1, 3, 32'hD3, 1'b0, '0);
        cycle(0, 0, '0, 1'b0, 4'b0010);
        check_eq("clrlock_chan", 64'(oup_chan), 64'd3);
        cycle(0, 0, '0, 1'b0, '0);
        check_eq("clrlock_chan2", 64'(oup_chan), 64'd3);
        check_eq("clrlock_valid", 64'(oup_valid), 64'd1);
        drain();

        // Async reset with three channels partly filled, then a fresh push/pop.
        for (int c = 0; c < 3; c++) begin
            cycle(1, c, DW'(32'hE0 + c), 1'b0, '0);
            cycle(1, c, DW'(32'hF0 + c), 1'b0, '0);
        end
        reset_pulse();
        cycle(1, 0, 32'h55, 1'b0, '0);
        cycle(0, 0, '0, 1'b1, '0);
        check_eq("post_rst_data", 64'(oup_data), 64'h55);

        // Random traffic, including same-channel push/pop and occasional clears.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 2) == 0, int'($urandom % NC), DW'($urandom),
                  ($urandom % 4) != 0,
                  (($urandom % 16) == 0) ? NC'(1 << ($urandom % NC)) : NC'(0));
        end
        drain();

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
